imem_dmem_arbiter: RTL and testbench
====================================

Name: imem_dmem_arbiter

Overview:
- Shares the SoC's single-port instruction/data memory between two core-side requesters: the load/store unit (m0) and the instruction fetch unit (m1).
- Sits between the core and the memory instance inside the SoC top.
- Arbitration is fixed-priority in favour of m0, with a starvation guard for m1.
- The memory has a one-cycle read latency. The arbiter returns each read response to the master that issued it.

Parameters:
- ADDR_W, 32, byte address width of both masters and the memory port.
- DATA_W, 32, data width.
- STARVE_LIM, 4, number of consecutive denied m1 cycles after which m1 takes priority for one arbitration.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low (0 = reset, 1 = run).
- m0_req  in  1  LSU access request.
- m0_we  in  1  1 = write, 0 = read.
- m0_be  in  4  byte enables, writes only.
- m0_addr  in  ADDR_W  byte address.
- m0_wdata  in  DATA_W  write data.
- m0_gnt  out  1  access accepted this cycle.
- m0_rvalid  out  1  read data valid.
- m0_rdata  out  DATA_W  read data.
- m1_req, m1_addr, m1_gnt, m1_rvalid, m1_rdata  same as the m0 equivalents; fetch is read-only (no we/be/wdata).
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write.
- mem_be  out  4  memory byte enables.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en with mem_we=0.

Behaviour:
- Reset (rst=0, asynchronous):
  - Registered state cleared: resp_owner=0, resp_pend=0, starve_cnt=0.
  - While rst=0, m0_gnt, m1_gnt and mem_en are forced to 0.
  - m0_rvalid and m1_rvalid are 0.
  - m0_rdata and m1_rdata are 0.
- Grant is combinational, in the same cycle as the request:
  - starve_hit = (starve_cnt == STARVE_LIM).
  - If m1_req && (starve_hit || !m0_req), then m1_gnt=1; otherwise m0_gnt = m0_req.
  - At most one grant per cycle.
- Request hold rule: a master holds req, addr, we, be and wdata stable until it sees gnt=1. A request dropped before grant is legal and has no effect.
- Memory mux:
  - mem_en = m0_gnt | m1_gnt.
  - mem_addr, mem_we, mem_be and mem_wdata come from the granted master.
  - For m1: mem_we=0 and mem_be=4'hF.
  - With no grant, all mem_* outputs are 0.
- Read response (registered):
  - On a clock edge with a granted read, resp_pend<=1 and resp_owner<=granted index; otherwise resp_pend<=0.
  - The cycle after the grant, mN_rvalid = resp_pend && (resp_owner==N).
  - mN_rdata = mem_rdata when its rvalid=1, otherwise 0.
  - Writes produce no rvalid. A write completes at the grant edge.
- Back-to-back operation: a new grant may issue in the same cycle as the previous read's rvalid, giving full throughput of one access per cycle.
- Starvation counter (width $clog2(STARVE_LIM+1)):
  - If m1_req && !m1_gnt and starve_cnt<STARVE_LIM, then starve_cnt<=starve_cnt+1.
  - If m1_gnt, then starve_cnt<=0.
  - If !m1_req, then starve_cnt<=0.
  - The counter saturates at STARVE_LIM and never wraps.
- Simultaneous events: m0 and m1 requesting together with starve_cnt<STARVE_LIM grants m0.
  - After STARVE_LIM consecutive m0 wins, m1 wins the next cycle.
  - The counter then clears and m0 regains priority.
- Reset mid-operation: a pending rvalid is discarded. No rvalid is issued after rst releases until a new read is granted.

Test Plan:
- Reset check: hold rst=0 with m0_req=m1_req=1 -> both gnt=0, mem_en=0, both rvalid=0.
  - Release rst -> m0_gnt=1 in the same cycle.
- m1 read only: m1_req=1, m1_addr=0x100, memory word 0x00000013 -> m1_gnt=1 and mem_addr=0x100 in cycle 0.
  - Cycle 1: m1_rvalid=1, m1_rdata=0x00000013, m0_rvalid=0.
- m0 write then read:
  - m0 writes 0xDEADBEEF to 0x200 with be=4'b0011 -> mem_we=1, mem_be=4'b0011, no rvalid.
  - A following m0 read of 0x200 -> m0_rvalid the next cycle, with data whose low half is 0xBEEF.
- Contention and starvation: m0_req and m1_req held at 1 continuously, STARVE_LIM=4.
  - Grant sequence: m0,m0,m0,m0,m1,m0,m0,m0,m0,m1,...
  - starve_cnt values: 0,1,2,3,4,0,...
- Interleaved responses: m0 read granted in cycle N, m1 read granted in cycle N+1 -> m0_rvalid in N+1, m1_rvalid in N+2, each carrying its own address's data.
- Reset mid-read: assert rst=0 in the cycle after an m1 read grant -> m1_rvalid=0 immediately.
  - After release with no requests, no rvalid is ever asserted.

Source files
------------

// File: rtl/imem_dmem_arbiter.sv
// Fixed-priority arbiter sharing one single-port memory between the LSU (m0) and
// instruction fetch (m1), with a starvation guard for m1 and owner-tagged read responses.
module imem_dmem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [3:0]        m0_be,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned     CntW      = $clog2(STARVE_LIM + 1);
    localparam logic [CntW-1:0] StarveLim = CntW'(STARVE_LIM);

    logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
    logic            resp_pend_q, resp_pend_d;
    logic            resp_owner_q, resp_owner_d;
    logic            starve_hit;

    // Grants are gated by rst so nothing reaches memory while reset is held.
    always_comb begin
        starve_hit = (starve_cnt_q == StarveLim);
        m1_gnt     = rst & m1_req & (starve_hit | ~m0_req);
        m0_gnt     = rst & m0_req & ~m1_gnt;
    end

    always_comb begin
        mem_en    = m0_gnt | m1_gnt;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (m0_gnt) begin
            mem_we    = m0_we;
            mem_be    = m0_be;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else if (m1_gnt) begin
            mem_be    = 4'hF;
            mem_addr  = m1_addr;
        end
    end

    always_comb begin
        resp_pend_d  = mem_en & ~mem_we;
        resp_owner_d = m1_gnt;
        starve_cnt_d = starve_cnt_q;
        if (!m1_req || m1_gnt) begin
            starve_cnt_d = '0;
        end else if (!starve_hit) begin
            starve_cnt_d = starve_cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_q <= '0;
            resp_pend_q  <= 1'b0;
            resp_owner_q <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            resp_pend_q  <= resp_pend_d;
            resp_owner_q <= resp_owner_d;
        end
    end

    always_comb begin
        m0_rvalid = resp_pend_q & ~resp_owner_q;
        m1_rvalid = resp_pend_q & resp_owner_q;
        m0_rdata  = m0_rvalid ? mem_rdata : '0;
        m1_rdata  = m1_rvalid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter: a behavioural one-cycle memory plus per-master
// scoreboards of expected read data, checked with immediate assertions every cycle.
module tb_imem_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we;
    logic [3:0]  m0_be;
    logic [31:0] m0_addr, m0_wdata;
    logic        m0_gnt, m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m1_req;
    logic [31:0] m1_addr;
    logic        m1_gnt, m1_rvalid;
    logic [31:0] m1_rdata;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic        pend0 = 1'b0;
    logic        pend1 = 1'b0;

    logic [31:0] mem [256];

    always #5 clk = ~clk;

    imem_dmem_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .STARVE_LIM(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_req   (m0_req),
        .m0_we    (m0_we),
        .m0_be    (m0_be),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_gnt   (m0_gnt),
        .m0_rvalid(m0_rvalid),
        .m0_rdata (m0_rdata),
        .m1_req   (m1_req),
        .m1_addr  (m1_addr),
        .m1_gnt   (m1_gnt),
        .m1_rvalid(m1_rvalid),
        .m1_rdata (m1_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_be   (mem_be),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Single-port memory with one-cycle read latency; garbage when not reading.
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            mem_rdata <= 32'hBAD0_BAD0;
        end else if (mem_en) begin
            mem_rdata <= mem[mem_addr[9:2]];
        end else begin
            mem_rdata <= 32'hBAD0_BAD0;
        end
    end

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'hA500_0000 | a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at posedge+1, check mid-cycle, return at next posedge+1.
    task automatic cyc(input string tag,
                       input logic r0, input logic we0, input logic [3:0] be0,
                       input logic [31:0] a0, input logic [31:0] wd0,
                       input logic r1, input logic [31:0] a1,
                       input logic eg0, input logic eg1, input logic [31:0] ed);
        m0_req = r0; m0_we = we0; m0_be = be0; m0_addr = a0; m0_wdata = wd0;
        m1_req = r1; m1_addr = a1;
        #3;
        chk({tag, "_g0"}, 32'(m0_gnt), 32'(eg0));
        chk({tag, "_g1"}, 32'(m1_gnt), 32'(eg1));
        chk({tag, "_en"}, 32'(mem_en), 32'(eg0 | eg1));
        if (eg0) begin
            chk({tag, "_addr"}, mem_addr, a0);
            chk({tag, "_we"}, 32'(mem_we), 32'(we0));
            chk({tag, "_be"}, 32'(mem_be), 32'(be0));
            if (we0) chk({tag, "_wd"}, mem_wdata, wd0);
        end else if (eg1) begin
            chk({tag, "_addr"}, mem_addr, a1);
            chk({tag, "_we"}, 32'(mem_we), 32'd0);
            chk({tag, "_be"}, 32'(mem_be), 32'hF);
        end else begin
            chk({tag, "_addr"}, mem_addr, 32'd0);
        end
        chk({tag, "_rv0"}, 32'(m0_rvalid), 32'(pend0));
        if (pend0 && q0.size() > 0) chk({tag, "_rd0"}, m0_rdata, q0.pop_front());
        else chk({tag, "_rd0z"}, m0_rdata, 32'd0);
        chk({tag, "_rv1"}, 32'(m1_rvalid), 32'(pend1));
        if (pend1 && q1.size() > 0) chk({tag, "_rd1"}, m1_rdata, q1.pop_front());
        else chk({tag, "_rd1z"}, m1_rdata, 32'd0);
        pend0 = eg0 && !we0;
        pend1 = eg1;
        if (pend0) q0.push_back(ed);
        if (pend1) q1.push_back(ed);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = word(32'(i * 4));
        mem[32'h100 >> 2] = 32'h0000_0013;
        mem[32'h200 >> 2] = 32'h1122_3344;

        rst = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_be = 4'h0; m0_addr = 32'h0; m0_wdata = 32'h0;
        m1_req = 1'b1; m1_addr = 32'h4;
        repeat (2) @(posedge clk);
        #4;
        chk("rst_g0", 32'(m0_gnt), 32'd0);
        chk("rst_g1", 32'(m1_gnt), 32'd0);
        chk("rst_en", 32'(mem_en), 32'd0);
        chk("rst_rv0", 32'(m0_rvalid), 32'd0);
        chk("rst_rv1", 32'(m1_rvalid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc("rel", 1, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 1, 0, word(32'h0));
        cyc("idle0", 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 32'h0);

        cyc("m1rd", 0, 0, 4'h0, 32'h0, 32'h0, 1, 32'h100, 0, 1, 32'h0000_0013);
        cyc("idle1", 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 32'h0);

        cyc("m0wr", 1, 1, 4'b0011, 32'h200, 32'hDEAD_BEEF, 0, 32'h0, 1, 0, 32'h0);
        cyc("m0rd", 1, 0, 4'h0, 32'h200, 32'h0, 0, 32'h0, 1, 0, 32'h1122_BEEF);
        cyc("idle2", 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 32'h0);

        // Both requesting continuously: m1 wins every fifth cycle.
        for (int i = 0; i < 11; i++) begin
            logic        w1;
            logic [31:0] a0, a1;
            w1 = (i % 5 == 4);
            a0 = 32'h40 + 32'(i * 4);
            a1 = 32'h80 + 32'(i * 4);
            cyc($sformatf("starve%0d", i), 1, 0, 4'h0, a0, 32'h0, 1, a1, !w1, w1,
                w1 ? word(a1) : word(a0));
        end
        cyc("idle3", 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 32'h0);

        cyc("ilv0", 1, 0, 4'h0, 32'h10, 32'h0, 1, 32'h20, 1, 0, word(32'h10));
        cyc("ilv1", 0, 0, 4'h0, 32'h0, 32'h0, 1, 32'h20, 0, 1, word(32'h20));
        cyc("ilv2", 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 32'h0);

        cyc("mrd", 0, 0, 4'h0, 32'h0, 32'h0, 1, 32'h30, 0, 1, word(32'h30));
        rst = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0;
        #3;
        chk("mid_rv1", 32'(m1_rvalid), 32'd0);
        chk("mid_rd1", m1_rdata, 32'd0);
        chk("mid_en", 32'(mem_en), 32'd0);
        pend0 = 1'b0; pend1 = 1'b0;
        q0.delete(); q1.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++)
            cyc($sformatf("post%0d", i), 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
